// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key schedule and the round datapath.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StDone
    } aes_state_e;

    localparam int unsigned NUM_ROUNDS = 10;

    // Rcon[1..10]; unused slots are zero so any 4-bit round index is safe.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    // Cyclic left rotation by one byte.
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, 8 bits in, 8 bits out.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Entry 0 sits in the top byte, so entry i is at bits 2047-8i downwards.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_pos;

    // Index the table from the top.
    always_comb begin
        bit_pos = 11'd2047 - {din, 3'b000};
        dout    = SBOX[bit_pos -: 8];
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule with an indexed round-key buffer.
// Define AES_KEY_EXPAND_SERIAL_SBOX_EN for a single shared S-box (4 cycles per round).
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         finish,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    aes_state_e state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       finish_q, finish_d;
    logic       load_key, step, round_done;
    aes_block_t rk_q [NUM_ROUNDS+1];

    aes_block_t prev_rk, next_rk;
    aes_word_t  rot, sub, t, n0, n1, n2, n3;

    assign prev_rk = rk_q[round_q - 4'd1];
    assign rot     = rot_word(prev_rk[31:0]);

`ifdef AES_KEY_EXPAND_SERIAL_SBOX_EN
    logic [1:0] byte_q;
    aes_word_t  sub_q;
    logic [7:0] sbox_in, sbox_out;

    // Pick the rotated byte that the shared S-box handles this cycle.
    always_comb begin
        sbox_in = rot[31:24];
        case (byte_q)
            2'd0: sbox_in = rot[31:24];
            2'd1: sbox_in = rot[23:16];
            2'd2: sbox_in = rot[15:8];
            2'd3: sbox_in = rot[7:0];
            default: sbox_in = rot[31:24];
        endcase
    end

    aes_sbox u_sbox (.din(sbox_in), .dout(sbox_out));

    assign round_done = (byte_q == 2'd3);
    assign sub        = {sub_q[31:8], sbox_out};

    // Collect SubWord bytes; leaving EXPAND drops any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_q <= 2'd0;
            sub_q  <= '0;
        end else if (state_q == StExpand && start) begin
            byte_q <= byte_q + 2'd1;
            case (byte_q)
                2'd0: sub_q[31:24] <= sbox_out;
                2'd1: sub_q[23:16] <= sbox_out;
                2'd2: sub_q[15:8]  <= sbox_out;
                default: sub_q[7:0] <= sbox_out;
            endcase
        end else begin
            byte_q <= 2'd0;
        end
    end
`else
    assign round_done = 1'b1;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.din(rot[8*b +: 8]), .dout(sub[8*b +: 8]));
    end
`endif

    assign t       = sub ^ {RCON[round_q], 24'h0};
    assign n0      = prev_rk[127:96] ^ t;
    assign n1      = prev_rk[95:64] ^ n0;
    assign n2      = prev_rk[63:32] ^ n1;
    assign n3      = prev_rk[31:0] ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            round_q  <= 4'd0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            finish_q <= finish_d;
        end
    end

    // Next-state logic: start is a level, dropping it always returns to idle.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        finish_d = finish_q;
        load_key = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !finish_q) begin
                    state_d  = StExpand;
                    round_d  = 4'd1;
                    load_key = 1'b1;
                end
            end
            StExpand: begin
                if (!start) begin
                    state_d = StIdle;
                    round_d = 4'd0;
                end else if (round_done) begin
                    step = 1'b1;
                    if (round_q == 4'(NUM_ROUNDS)) begin
                        state_d  = StDone;
                        finish_d = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            StDone: begin
                if (!start) begin
                    state_d  = StIdle;
                    round_d  = 4'd0;
                    finish_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Round-key buffer: rk[0] takes the key at run start, then one slot per round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else if (load_key) begin
            rk_q[0] <= key;
        end else if (step) begin
            rk_q[round_q] <= next_rk;
        end
    end

    assign finish = finish_q;
    assign rd_key = (rd_idx <= 4'(NUM_ROUNDS)) ? rk_q[rd_idx] : '0;

endmodule
